// File: rtl/mem_march_master.sv
`default_nettype none
// ============================================================================
// mem_march_master : three-phase march test master for a 1-cycle-latency SRAM
// Revision 1.0
// ============================================================================
module mem_march_master #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] pattern,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH+1:0] fail_count,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_exp,
  output logic [DATA_WIDTH-1:0] fail_got,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd_en,
  output logic                  mem_wr_en,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [ADDR_WIDTH-1:0] c_last_addr = '1;
  localparam logic [ADDR_WIDTH+1:0] c_count_max = '1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    W_BG  = 3'd1,
    R_P   = 3'd2,
    W_INV = 3'd3,
    R_INV = 3'd4,
    DRAIN = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_pat;

  logic                  w_cmp_en;
  logic [DATA_WIDTH-1:0] w_cmp_exp;
  logic [ADDR_WIDTH-1:0] w_cmp_addr;
  logic                  w_mismatch;

  // Read data returned this cycle belongs to the read issued last cycle.
  // In R_INV that was one address higher; the first R_INV cycle has nothing due.
  always_comb begin
    w_cmp_en   = 1'b0;
    w_cmp_exp  = ~r_pat;
    w_cmp_addr = '0;
    case (r_state)
      W_INV: begin
        w_cmp_en   = 1'b1;
        w_cmp_exp  = r_pat;
        w_cmp_addr = r_addr;
      end
      R_INV: begin
        w_cmp_en   = (r_addr != c_last_addr);
        w_cmp_addr = r_addr + ADDR_WIDTH'(1);
      end
      DRAIN:   w_cmp_en = 1'b1;
      default: w_cmp_en = 1'b0;
    endcase
  end

  assign w_mismatch = w_cmp_en && (mem_rdata != w_cmp_exp);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_pat      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_count <= '0;
      fail_addr  <= '0;
      fail_exp   <= '0;
      fail_got   <= '0;
      mem_addr   <= '0;
      mem_rd_en  <= 1'b0;
      mem_wr_en  <= 1'b0;
      mem_wdata  <= '0;
    end else begin
      if (w_mismatch) begin
        if (fail_count != c_count_max) begin
          fail_count <= fail_count + (ADDR_WIDTH+2)'(1);
        end
        // The count is zero only until the first mismatch of the run.
        if (fail_count == '0) begin
          fail_addr <= w_cmp_addr;
          fail_exp  <= w_cmp_exp;
          fail_got  <= mem_rdata;
        end
      end

      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_pat      <= pattern;
            fail_count <= '0;
            fail_addr  <= '0;
            fail_exp   <= '0;
            fail_got   <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
            busy       <= 1'b1;
            r_state    <= W_BG;
            r_addr     <= '0;
            mem_addr   <= '0;
            mem_wr_en  <= 1'b1;
            mem_wdata  <= pattern;
          end
        end

        W_BG: begin
          if (r_addr == c_last_addr) begin
            r_state   <= R_P;
            r_addr    <= '0;
            mem_addr  <= '0;
            mem_wr_en <= 1'b0;
            mem_rd_en <= 1'b1;
            mem_wdata <= '0;
          end else begin
            r_addr   <= r_addr + ADDR_WIDTH'(1);
            mem_addr <= r_addr + ADDR_WIDTH'(1);
          end
        end

        R_P: begin
          r_state   <= W_INV;
          mem_rd_en <= 1'b0;
          mem_wr_en <= 1'b1;
          mem_wdata <= ~r_pat;
        end

        W_INV: begin
          mem_wr_en <= 1'b0;
          mem_rd_en <= 1'b1;
          mem_wdata <= '0;
          if (r_addr == c_last_addr) begin
            r_state <= R_INV;
          end else begin
            r_state  <= R_P;
            r_addr   <= r_addr + ADDR_WIDTH'(1);
            mem_addr <= r_addr + ADDR_WIDTH'(1);
          end
        end

        R_INV: begin
          if (r_addr == '0) begin
            r_state   <= DRAIN;
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
          end else begin
            r_addr   <= r_addr - ADDR_WIDTH'(1);
            mem_addr <= r_addr - ADDR_WIDTH'(1);
          end
        end

        DRAIN: begin
          r_state <= DONE;
          busy    <= 1'b0;
          done    <= 1'b1;
          // The last compare lands on this same edge, so fold it into pass.
          pass    <= (fail_count == '0) && !w_mismatch;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_march_master.sv
`default_nettype none
// tb_mem_march_master : scoreboard bench with a 1-cycle-latency memory model
// and an optional bit0 stuck-at-1 fault at address 5.
module tb_mem_march_master;
  localparam int AW = 4;
  localparam int DW = 16;
  localparam int N  = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [DW-1:0] pattern;
  logic          busy, done, pass;
  logic [AW+1:0] fail_count;
  logic [AW-1:0] fail_addr;
  logic [DW-1:0] fail_exp, fail_got;
  logic [AW-1:0] mem_addr;
  logic          mem_rd_en, mem_wr_en;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  int n_checks = 0;
  int n_fail   = 0;
  logic mon_on   = 1'b0;
  logic stuck_en = 1'b0;

  logic [DW-1:0] mem [N];
  logic [21:0]   exp_bus [$];
  logic [43:0]   exp_res [$];

  always #5 clk = ~clk;

  mem_march_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern),
    .busy(busy), .done(done), .pass(pass), .fail_count(fail_count),
    .fail_addr(fail_addr), .fail_exp(fail_exp), .fail_got(fail_got),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr] <= mem_wdata;
    if (mem_rd_en) mem_rdata <= mem[mem_addr] | ((stuck_en && mem_addr == 4'd5) ? 16'h0001 : 16'h0000);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [43:0] res_pack(input logic d, input logic p, input logic [5:0] fc,
                                           input logic [3:0] fa, input logic [15:0] fe,
                                           input logic [15:0] fg);
    return {d, p, fc, fa, fe, fg};
  endfunction

  // Bus monitor: one expected bus op per busy cycle, idle bus otherwise.
  always @(negedge clk) begin
    if (mon_on) begin
      check("bus_excl", 64'(mem_rd_en & mem_wr_en), 64'd0);
      if (busy === 1'b1) begin
        if (exp_bus.size() == 0) check("bus_q_empty", 64'(busy), 64'd0);
        else check("bus_op", 64'({mem_rd_en, mem_wr_en, mem_addr, mem_wdata}), 64'(exp_bus.pop_front()));
      end else begin
        check("bus_idle", 64'({mem_rd_en, mem_wr_en, mem_addr, mem_wdata}), 64'd0);
      end
    end
  end

  task automatic push_run(input logic [DW-1:0] p, input logic [43:0] res);
    logic [AW-1:0] a;
    for (int i = 0; i < N; i++) begin a = AW'(i); exp_bus.push_back({1'b0, 1'b1, a, p}); end
    for (int i = 0; i < N; i++) begin
      a = AW'(i);
      exp_bus.push_back({1'b1, 1'b0, a, 16'h0000});
      exp_bus.push_back({1'b0, 1'b1, a, ~p});
    end
    for (int i = N - 1; i >= 0; i--) begin a = AW'(i); exp_bus.push_back({1'b1, 1'b0, a, 16'h0000}); end
    exp_bus.push_back(22'd0);
    exp_res.push_back(res);
  endtask

  // Called just after a rising edge; that edge's successor accepts the start.
  task automatic do_start(input logic [DW-1:0] p, input logic [43:0] res);
    push_run(p, res);
    start = 1'b1; pattern = p;
    @(posedge clk); #1;
    start = 1'b0; pattern = 16'hDEAD;
    check("busy_rise", 64'(busy), 64'd1);
    check("start_clear", 64'({done, pass, fail_count, fail_addr, fail_exp, fail_got}), 64'd0);
  endtask

  task automatic wait_done(input int pulse_at);
    int cycles;
    logic [43:0] expr;
    cycles = 1;
    while (busy === 1'b1 && cycles < 200) begin
      @(posedge clk); #1;
      if (busy === 1'b1) cycles++;
      start = (pulse_at != 0 && cycles == pulse_at && busy === 1'b1);
      if (start) pattern = 16'h1234;
    end
    start = 1'b0;
    check("busy_cycles", 64'(cycles), 64'd65);
    check("done_rise", 64'(done), 64'd1);
    if (exp_res.size() == 0) check("res_q_empty", 64'(done), 64'd0);
    else begin
      expr = exp_res.pop_front();
      check("result", 64'({done, pass, fail_count, fail_addr, fail_exp, fail_got}), 64'(expr));
    end
  endtask

  task automatic check_mem(input logic [DW-1:0] v);
    for (int i = 0; i < N; i++) check("mem_final", 64'(mem[i]), 64'(v));
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; pattern = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    check("rst_status", 64'({busy, done, pass, fail_count, fail_addr, fail_exp, fail_got}), 64'd0);
    check("rst_bus", 64'({mem_addr, mem_rd_en, mem_wr_en, mem_wdata}), 64'd0);
    mon_on = 1'b1;

    // Fault-free run
    do_start(16'hA5A5, res_pack(1'b1, 1'b1, 6'd0, 4'd0, 16'h0, 16'h0));
    wait_done(0);
    check_mem(16'h5A5A);

    // Stuck-at-1, background 0: caught in ascending phase; started back-to-back
    stuck_en = 1'b1;
    do_start(16'h0000, res_pack(1'b1, 1'b0, 6'd1, 4'd5, 16'h0000, 16'h0001));
    wait_done(0);

    // Stuck-at-1, background FFFF: caught only in descending phase
    do_start(16'hFFFF, res_pack(1'b1, 1'b0, 6'd1, 4'd5, 16'h0000, 16'h0001));
    wait_done(0);
    stuck_en = 1'b0;

    // Start re-pulsed mid-run is ignored
    do_start(16'h3C3C, res_pack(1'b1, 1'b1, 6'd0, 4'd0, 16'h0, 16'h0));
    wait_done(10);
    check_mem(16'hC3C3);

    // Reset at cycle 20 of a run
    do_start(16'h1111, res_pack(1'b1, 1'b1, 6'd0, 4'd0, 16'h0, 16'h0));
    repeat (19) begin @(posedge clk); #1; end
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    check("midrst_status", 64'({busy, done, pass, fail_count, fail_addr, fail_exp, fail_got}), 64'd0);
    check("midrst_bus", 64'({mem_addr, mem_rd_en, mem_wr_en, mem_wdata}), 64'd0);
    exp_bus.delete();
    exp_res.delete();
    repeat (2) begin @(posedge clk); #1; end
    check("midrst_idle", 64'({busy, done}), 64'd0);
    do_start(16'h0F0F, res_pack(1'b1, 1'b1, 6'd0, 4'd0, 16'h0, 16'h0));
    wait_done(0);
    check_mem(16'hF0F0);

    repeat (3) begin @(posedge clk); #1; end
    check("done_hold", 64'({done, pass, busy}), 64'b110);
    mon_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/mem_march_master.md
# mem_march_master

Initiator-side test master for the single-port synchronous memory interface: addr, rd_en, wr_en, wdata and rdata, with one-cycle read latency. On a start pulse it runs a three-phase march test over every address:
- write a background pattern,
- read-verify and write its inverse (ascending),
- read-verify the inverse (descending).

It reports pass/fail and captures the first mismatch. It sits between system/test control and the memory array, and owns the memory port while busy.

## Interface
- ADDR_WIDTH, 4, memory address width; depth N = 2**ADDR_WIDTH
- DATA_WIDTH, 16, memory data width
- clk  input  1  clock, all logic on rising edge
- reset  input  1  synchronous, active-low reset
- start  input  1  one-cycle request; sampled only in IDLE
- pattern  input  DATA_WIDTH  background pattern P, captured when start is accepted
- busy  output  1  test in progress
- done  output  1  level; high from test completion until next accepted start
- pass  output  1  valid while done; 1 iff fail_count == 0
- fail_count  output  ADDR_WIDTH+2  mismatch count, saturating at all-ones
- fail_addr  output  ADDR_WIDTH  address of first mismatch
- fail_exp  output  DATA_WIDTH  expected data of first mismatch
- fail_got  output  DATA_WIDTH  read data of first mismatch
- mem_addr  output  ADDR_WIDTH  memory address
- mem_rd_en  output  1  memory read enable
- mem_wr_en  output  1  memory write enable
- mem_wdata  output  DATA_WIDTH  memory write data
- mem_rdata  input  DATA_WIDTH  memory read data, valid the cycle after the rd_en cycle

## Operation
- **States:** IDLE, W_BG, R_P, W_INV, R_INV, DRAIN, DONE. DONE behaves as IDLE, but done stays high.
- **IDLE/DONE, start=1:**
  - Capture P.
  - Clear fail_count, fail_addr, fail_exp, fail_got, done, pass.
  - Set busy; go to W_BG with address 0.
- **W_BG:** write P at addresses 0..N-1, one per cycle. After N-1, go to R_P at address 0.
- **R_P then W_INV (ascending, per address a):**
  - R_P cycle: rd_en at a.
  - W_INV cycle: compare mem_rdata against P, and write ~P at a.
  - After a = N-1, go to R_INV at address N-1.
- **R_INV:**
  - Read addresses N-1 down to 0, one per cycle.
  - Each read is compared against ~P in the following cycle (pipelined).
  - After address 0, go to DRAIN.
- **DRAIN:** no enables; performs the final compare (address 0). Then go to DONE.
- **DONE entry:** busy=0, done=1, pass=(fail_count==0).
- **Mismatch handling:**
  - Every mismatch increments fail_count; saturate, never wrap.
  - Only the first mismatch of a run loads fail_addr/fail_exp/fail_got.
  - The test always runs to completion; no abort.
- **Bus rules:**
  - mem_rd_en and mem_wr_en are never high together.
  - Both are low in IDLE, DRAIN and DONE.
  - mem_addr and mem_wdata are 0 when no enable is high.
- start while busy is ignored.
- Address counter arithmetic is ADDR_WIDTH wide. Phase terminals are detected by compare (N-1 ascending, 0 descending), never by wrap.

## Timing
- **Reset:** reset=0 at a rising edge forces IDLE. Every output goes to 0 after that edge, including mid-test. A partial test leaves memory contents undefined; no completion is reported.
- **Start:** accepted at edge E0 → the first write (address 0) and busy=1 appear in the cycle after E0.
- **Phase durations:** W_BG N cycles, R_P/W_INV 2N cycles, R_INV N cycles, DRAIN 1 cycle. busy is high for exactly 4N+1 cycles (65 for N=16).
- **Done:** done/pass rise on the same edge busy falls.
- **Compare timing:** each compare is registered at the end of the cycle following its read. fail_* and fail_count update on that edge.
- **Back-to-back:** start in the first DONE cycle is accepted, with busy rising the next cycle.

## Test plan
- **Fault-free run:** fault-free memory model with 1-cycle read latency, N=16, pattern=16'hA5A5 → busy 65 cycles; address order 0..15, (0,0)..(15,15), 15..0; done=1, pass=1, fail_count=0; memory ends all 16'h5A5A.
- **Stuck-at-1, pattern 0:** model with bit0 of address 5 stuck-at-1, pattern=16'h0000 → fail_count=1, fail_addr=5, fail_exp=16'h0000, fail_got=16'h0001, pass=0.
- **Stuck-at-1, pattern FFFF:** same fault, pattern=16'hFFFF → single mismatch in the descending phase: fail_addr=5, fail_exp=16'h0000, fail_got=16'h0001, fail_count=1.
- **Restart:** start re-pulsed at cycle 10 of a run → ignored, completion still at 65 cycles. A new start in DONE clears done/pass/fail_* and reruns.
- **Reset mid-run:** reset=0 at cycle 20 → next cycle all outputs 0, state IDLE. A subsequent start completes a full 65-cycle run with pass=1.
- **Bus protocol check:** over all runs, mem_rd_en & mem_wr_en is never 1; enables are low in IDLE/DONE; no address outside 0..N-1.
